// File: rtl/hazard_ctrl_mc.sv
// Hazard/forwarding controller: M/W forwarding, load-use/branch/MDU interlocks, saturating stall counter.
// Combinational outputs are valid the same cycle; the MDU FSM and stall counter are registered. Optional D-stage branch support is enabled by HAZ_BRANCH_FWD_EN.
module hazard_ctrl_mc #(
    parameter int REG_AW  = 5,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rt_e,
    input  logic [REG_AW-1:0] wreg_e,
    input  logic [REG_AW-1:0] wreg_m,
    input  logic [REG_AW-1:0] wreg_w,
    input  logic              regwr_e,
    input  logic              regwr_m,
    input  logic              regwr_w,
    input  logic              mem2reg_e,
    input  logic              mem2reg_m,
    input  logic              branch_d,
    input  logic              mdu_start_e,
    input  logic              mdu_use_d,
    output logic              forward_ad,
    output logic              forward_bd,
    output logic [1:0]        forward_ae,
    output logic [1:0]        forward_be,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_e,
    output logic              mdu_busy,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int MCW = $clog2(MDU_LAT + 1);
    localparam logic [MCW-1:0] LAT_V = MCW'(MDU_LAT);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t           r_state, w_state_nxt;
    logic [MCW-1:0]   r_mcnt, w_mcnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_rs_e_m, w_rs_e_w, w_rt_e_m, w_rt_e_w;
    logic w_lw_stall, w_br_stall, w_mdu_stall, w_stall;

    // M-stage match is checked first so the youngest producer always wins.
    assign w_rs_e_m = (rs_e != '0) && (rs_e == wreg_m) && regwr_m;
    assign w_rs_e_w = (rs_e != '0) && (rs_e == wreg_w) && regwr_w;
    assign w_rt_e_m = (rt_e != '0) && (rt_e == wreg_m) && regwr_m;
    assign w_rt_e_w = (rt_e != '0) && (rt_e == wreg_w) && regwr_w;

    assign forward_ae = w_rs_e_m ? 2'b10 : (w_rs_e_w ? 2'b01 : 2'b00);
    assign forward_be = w_rt_e_m ? 2'b10 : (w_rt_e_w ? 2'b01 : 2'b00);

    assign w_lw_stall = mem2reg_e && (wreg_e != '0) && ((wreg_e == rs_d) || (wreg_e == rt_d));

`ifdef HAZ_BRANCH_FWD_EN
    assign forward_ad = (rs_d != '0) && (rs_d == wreg_m) && regwr_m;
    assign forward_bd = (rt_d != '0) && (rt_d == wreg_m) && regwr_m;
    assign w_br_stall = branch_d &&
        ((regwr_e && (wreg_e != '0) && ((wreg_e == rs_d) || (wreg_e == rt_d))) ||
         (mem2reg_m && (wreg_m != '0) && ((wreg_m == rs_d) || (wreg_m == rt_d))));
`else
    logic w_unused;
    assign w_unused   = branch_d ^ mem2reg_m;
    assign forward_ad = 1'b0;
    assign forward_bd = 1'b0;
    assign w_br_stall = 1'b0;
`endif

    assign mdu_busy    = (r_state == S_BUSY);
    assign w_mdu_stall = mdu_use_d && (mdu_busy || mdu_start_e);
    assign w_stall     = w_lw_stall || w_br_stall || w_mdu_stall;

    assign stall_f   = w_stall;
    assign stall_d   = w_stall;
    assign flush_e   = w_stall;
    assign stall_cnt = r_stall_cnt;

    // A start in BUSY reloads the full latency so back-to-back ops chain.
    always_comb begin
        w_state_nxt = r_state;
        w_mcnt_nxt  = r_mcnt;
        case (r_state)
            S_IDLE: begin
                if (mdu_start_e) begin
                    w_state_nxt = S_BUSY;
                    w_mcnt_nxt  = LAT_V;
                end
            end
            S_BUSY: begin
                if (mdu_start_e) begin
                    w_mcnt_nxt = LAT_V;
                end else if (r_mcnt == MCW'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_mcnt_nxt  = '0;
                end else begin
                    w_mcnt_nxt = r_mcnt - MCW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_mcnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mcnt  <= w_mcnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc: directed literal cases plus randomized traffic against a rule-level model.
module tb_hazard_ctrl_mc;
    localparam int REG_AW  = 5;
    localparam int MDU_LAT = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic [REG_AW-1:0] rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w;
    logic regwr_e, regwr_m, regwr_w, mem2reg_e, mem2reg_m, branch_d, mdu_start_e, mdu_use_d;
    logic forward_ad, forward_bd, stall_f, stall_d, flush_e, mdu_busy;
    logic [1:0] forward_ae, forward_be;
    logic [CNT_W-1:0] stall_cnt;

    hazard_ctrl_mc #(.REG_AW(REG_AW), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .wreg_e(wreg_e), .wreg_m(wreg_m), .wreg_w(wreg_w),
        .regwr_e(regwr_e), .regwr_m(regwr_m), .regwr_w(regwr_w),
        .mem2reg_e(mem2reg_e), .mem2reg_m(mem2reg_m), .branch_d(branch_d),
        .mdu_start_e(mdu_start_e), .mdu_use_d(mdu_use_d),
        .forward_ad(forward_ad), .forward_bd(forward_bd),
        .forward_ae(forward_ae), .forward_be(forward_be),
        .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
        .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model state: cycle index, cycle of last accepted MDU start, stall count.
    int cyc = 0;
    int last_start = -1000;
    int m_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_busy();
        return ((cyc - last_start) >= 1) && ((cyc - last_start) <= MDU_LAT);
    endfunction

    function automatic logic [1:0] m_fe(input logic [REG_AW-1:0] r);
        if (r != 0 && r == wreg_m && regwr_m) return 2'b10;
        if (r != 0 && r == wreg_w && regwr_w) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_fd(input logic [REG_AW-1:0] r);
`ifdef HAZ_BRANCH_FWD_EN
        return (r != 0) && (r == wreg_m) && regwr_m;
`else
        return (r == r) && 1'b0;
`endif
    endfunction

    function automatic bit m_stall();
        bit lw, br, md;
        lw = mem2reg_e && wreg_e != 0 && (wreg_e == rs_d || wreg_e == rt_d);
        br = 1'b0;
`ifdef HAZ_BRANCH_FWD_EN
        br = branch_d && ((regwr_e && wreg_e != 0 && (wreg_e == rs_d || wreg_e == rt_d)) ||
                          (mem2reg_m && wreg_m != 0 && (wreg_m == rs_d || wreg_m == rt_d)));
`endif
        md = mdu_use_d && (m_busy() || mdu_start_e);
        return lw || br || md;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_start = -1000;
            m_cnt = 0;
        end else begin
            if (m_stall()) m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
            if (mdu_start_e) last_start = cyc;
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_fwd_ae", 32'(forward_ae), 32'(m_fe(rs_e)));
            chk("cmp_fwd_be", 32'(forward_be), 32'(m_fe(rt_e)));
            chk("cmp_fwd_ad", 32'(forward_ad), 32'(m_fd(rs_d)));
            chk("cmp_fwd_bd", 32'(forward_bd), 32'(m_fd(rt_d)));
            chk("cmp_stall_f", 32'(stall_f), 32'(m_stall()));
            chk("cmp_stall_d", 32'(stall_d), 32'(m_stall()));
            chk("cmp_flush_e", 32'(flush_e), 32'(m_stall()));
            chk("cmp_busy", 32'(mdu_busy), 32'(m_busy()));
            chk("cmp_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        end
    end

    task automatic clear();
        rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
        wreg_e = '0; wreg_m = '0; wreg_w = '0;
        regwr_e = 0; regwr_m = 0; regwr_w = 0;
        mem2reg_e = 0; mem2reg_m = 0; branch_d = 0;
        mdu_start_e = 0; mdu_use_d = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b1;
        clear();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy", 32'(mdu_busy), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        chk("rst_stall", 32'(stall_d), 0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Forwarding priority M over W, and r0 never forwarded
        tick(); clear();
        rs_e = 3; wreg_m = 3; regwr_m = 1; wreg_w = 3; regwr_w = 1;
        #1 chk("fwd_m_wins", 32'(forward_ae), 2);
        tick(); regwr_m = 0;
        #1 chk("fwd_w", 32'(forward_ae), 1);
        tick(); rs_e = 0;
        #1 chk("fwd_r0", 32'(forward_ae), 0);

        // Load-use stall
        tick(); clear();
        mem2reg_e = 1; wreg_e = 7; rt_d = 7;
        #1 chk("lw_stall_f", 32'(stall_f), 1);
        chk("lw_flush_e", 32'(flush_e), 1);
        chk("lw_cnt0", 32'(stall_cnt), 0);
        tick(); clear();
        #1 chk("lw_cnt1", 32'(stall_cnt), 1);
        chk("lw_stall_gone", 32'(stall_d), 0);

        // Branch in D depending on E producer
        tick(); clear();
        branch_d = 1; rs_d = 5; regwr_e = 1; wreg_e = 5;
`ifdef HAZ_BRANCH_FWD_EN
        #1 chk("br_stall", 32'(stall_d), 1);
`else
        #1 chk("br_no_stall", 32'(stall_d), 0);
        chk("br_fwd_ad", 32'(forward_ad), 0);
`endif

        // Isolated MDU op with consumer held in D
        tick(); clear();
        mdu_start_e = 1; mdu_use_d = 1;
        #1 chk("mdu_c0_stall", 32'(stall_d), 1);
        chk("mdu_c0_busy", 32'(mdu_busy), 0);
        for (int k = 1; k <= 5; k++) begin
            tick(); mdu_start_e = 0;
            #1 chk("mdu_seq_busy", 32'(mdu_busy), (k <= 4) ? 1 : 0);
            chk("mdu_seq_stall", 32'(stall_d), (k <= 4) ? 1 : 0);
        end

        // Back-to-back: second start at cycle 2 extends busy through cycle 6
        for (int c = 0; c <= 7; c++) begin
            tick(); clear();
            mdu_start_e = (c == 0 || c == 2);
            #1 if (c >= 1) chk("mdu_b2b_busy", 32'(mdu_busy), (c <= 6) ? 1 : 0);
        end

        // Asynchronous reset in the middle of BUSY
        tick(); clear(); mdu_start_e = 1;
        tick(); mdu_start_e = 0;
        tick(); mdu_use_d = 1;
        #1 chk("mid_busy_pre", 32'(mdu_busy), 1);
        @(negedge clk); #1 rst_n = 1'b0;
        #1 chk("mid_rst_busy", 32'(mdu_busy), 0);
        chk("mid_rst_cnt", 32'(stall_cnt), 0);
        @(posedge clk); #2 rst_n = 1'b1;
        #1 chk("post_rst_stall", 32'(stall_d), 0);
        chk("post_rst_busy", 32'(mdu_busy), 0);

        // Counter saturation
        tick(); clear();
        mem2reg_e = 1; wreg_e = 7; rs_d = 7;
        repeat (20) tick();
        #1 chk("cnt_sat", 32'(stall_cnt), CNT_MAX);

        // Randomized traffic, with occasional asynchronous resets
        tick(); clear();
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (!rst_n) rst_n = 1'b1;
            rs_d = REG_AW'($urandom_range(0, 7)); rt_d = REG_AW'($urandom_range(0, 7));
            rs_e = REG_AW'($urandom_range(0, 7)); rt_e = REG_AW'($urandom_range(0, 7));
            wreg_e = REG_AW'($urandom_range(0, 7)); wreg_m = REG_AW'($urandom_range(0, 7));
            wreg_w = REG_AW'($urandom_range(0, 7));
            regwr_e = $urandom_range(0, 1) == 1; regwr_m = $urandom_range(0, 1) == 1;
            regwr_w = $urandom_range(0, 1) == 1;
            mem2reg_e = $urandom_range(0, 5) == 0; mem2reg_m = $urandom_range(0, 3) == 0;
            branch_d = $urandom_range(0, 3) == 0;
            mdu_start_e = $urandom_range(0, 6) == 0;
            mdu_use_d = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 299) == 0) begin
                #1 rst_n = 1'b0;
            end
        end

        tick();
        rst_n = 1'b1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl_mc.md
# hazard_ctrl_mc

Parametrised hazard and forwarding controller for the five-stage pipeline, extending single-cycle forwarding and stall detection with a multi-cycle multiply/divide unit (MDU) interlock and a saturating stall-cycle counter. Sits beside the datapath: it takes register specifiers and write enables from the D/E/M/W stages and drives the forwarding muxes and the F/D stall and E flush controls. Forwarding is strictly prioritised, M stage over W stage.

## Interface
- REG_AW, 5, register specifier width; register 0 is hardwired zero and never forwarded or interlocked.
- MDU_LAT, 4, MDU busy cycles per operation (legal range 1..15).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs_d, rt_d  in  REG_AW  source specifiers in D.
- rs_e, rt_e  in  REG_AW  source specifiers in E.
- wreg_e, wreg_m, wreg_w  in  REG_AW  destination specifiers in E/M/W.
- regwr_e, regwr_m, regwr_w  in  1  register write enables in E/M/W.
- mem2reg_e, mem2reg_m  in  1  instruction in E/M is a load.
- branch_d  in  1  branch in D (compares in D).
- mdu_start_e  in  1  MDU operation issuing from E this cycle.
- mdu_use_d  in  1  instruction in D reads the MDU result (HI/LO).
- forward_ad, forward_bd  out  1  D-stage comparator operand from M result.
- forward_ae, forward_be  out  2  E-stage ALU operand select: 00 register file, 01 W result, 10 M result.
- stall_f, stall_d, flush_e  out  1  pipeline hold and bubble insert.
- mdu_busy  out  1  MDU interlock active.
- stall_cnt  out  CNT_W  saturating count of cycles with stall_d high.

## Operation
- forward_ae = 10 if rs_e≠0 && rs_e==wreg_m && regwr_m; else 01 if rs_e≠0 && rs_e==wreg_w && regwr_w; else 00. forward_be identical on rt_e. M always wins over W.
- forward_ad = rs_d≠0 && rs_d==wreg_m && regwr_m; forward_bd identical on rt_d.
- lw_stall = mem2reg_e && wreg_e≠0 && (wreg_e==rs_d || wreg_e==rt_d).
- br_stall = branch_d && [(regwr_e && wreg_e≠0 && wreg_e∈{rs_d,rt_d}) || (mem2reg_m && wreg_m≠0 && wreg_m∈{rs_d,rt_d})].
- mdu_stall = mdu_use_d && (mdu_busy || mdu_start_e).
- stall_f = stall_d = flush_e = lw_stall || br_stall || mdu_stall.
- MDU FSM, states IDLE and BUSY, down-counter of ceil(log2(MDU_LAT+1)) bits:
  - IDLE: mdu_start_e → BUSY, counter loads MDU_LAT.
  - BUSY: counter decrements each cycle; at 1 → IDLE. mdu_start_e in BUSY reloads MDU_LAT and stays BUSY (back-to-back operations).
  - mdu_busy = (state == BUSY).
- stall_cnt increments on each clock with stall_d=1; holds at all-ones (no wrap).

## Timing
- Forwarding and stall/flush outputs are combinational from current inputs and registered FSM state; valid the same cycle.
- mdu_busy rises the cycle after mdu_start_e and stays high exactly MDU_LAT cycles for an isolated operation.
- mdu_start_e and mdu_use_d in the same cycle stall D that cycle and for the following MDU_LAT cycles.
- flush_e and mdu_start_e coinciding: start still accepted (the MDU instruction itself is in E, not the bubble).
- Reset (asynchronous, any time including mid-BUSY): state IDLE, counter 0, mdu_busy 0, stall_cnt 0. Combinational outputs follow inputs with mdu_busy=0.

## Configuration
- HAZ_BRANCH_FWD_EN defined: D-stage branch comparison supported; forward_ad/forward_bd and br_stall as above.
- Undefined: branches resolve in E; forward_ad/forward_bd tied 0, br_stall term removed; branch_d ignored.

## Test plan
- rs_e=3, wreg_m=3, regwr_m=1, wreg_w=3, regwr_w=1 → forward_ae=10; drop regwr_m → 01; rs_e=0 → 00.
- mem2reg_e=1, wreg_e=7, rt_d=7 → stall_f/stall_d/flush_e=1 one cycle; stall_cnt 0→1.
- HAZ_BRANCH_FWD_EN, branch_d=1, rs_d=5, regwr_e=1, wreg_e=5 → stall 1; without macro → stall 0, forward_ad=0.
- MDU_LAT=4: mdu_start_e pulse at cycle 0 → mdu_busy high cycles 1–4; mdu_use_d held → stalls cycles 1–4, none at 5; second start at cycle 2 → busy through cycle 6.
- rst_n low at cycle 2 of BUSY → mdu_busy and stall_cnt 0 immediately, no stall after release.
- CNT_W=4, stall_d held 20 cycles → stall_cnt saturates at 15.
